// File: rtl/simple_data_mem_if.sv
// simple_data_mem_if: load/store bus between the memory stage and the data RAM.
//   address      : byte address driven by the master (ALU result)
//   write_data   : word to store, driven by the master
//   write_enable : full-word store strobe, driven by the master
//   read_data    : addressed word, returned combinationally by the slave
interface simple_data_mem_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;

    modport master (
        output address,
        output write_data,
        output write_enable,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        output read_data
    );
endinterface

// File: rtl/simple_data_mem.sv
// simple_data_mem: word-organised data RAM behind the pipeline's load/store path.
// Reads are asynchronous so the memory stage can sample read_data on the same
// edge as its own inputs. Writes are full 32-bit words on the rising edge.
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous, active-high; clears every word and overrides a write
//   bus : simple_data_mem_if slave (address, write_data, write_enable, read_data)
module simple_data_mem #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    simple_data_mem_if.slave     bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("simple_data_mem: DEPTH must be a power of two >= 2");
    end

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;

    // Byte offset and bits above the array span are dropped: misaligned
    // accesses hit the containing word, and addresses alias modulo DEPTH*4.
    assign idx = bus.address[IDX_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[31:IDX_W+2], bus.address[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
        end else if (bus.write_enable) begin
            mem[idx] <= bus.write_data;
        end
    end

    // No forwarding: a same-cycle write shows up only after the edge.
    assign bus.read_data = mem[idx];

endmodule

// File: tb/tb_simple_data_mem.sv
module tb_simple_data_mem;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    simple_data_mem_if bus ();

    simple_data_mem #(
        .DEPTH (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (bus.read_data === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, bus.read_data, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        bus.address      = addr;
        bus.write_data   = data;
        bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp);
        bus.address = addr;
        #1;
        check(tag, exp);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        bus.address      = 32'h0;
        bus.write_data   = 32'h0;
        bus.write_enable = 1'b0;
        #2;

        // Reset clear
        write_word(32'h10, 32'hDEAD_BEEF);
        read_check("pre_reset_write", 32'h10, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        check("old_data_during_rst_cycle", 32'hDEAD_BEEF);
        tick();
        rst = 1'b0;
        read_check("reset_0x10", 32'h10, 32'h0);
        read_check("reset_0x0", 32'h0, 32'h0);
        read_check("reset_0xffc", 32'hFFC, 32'h0);

        // Write / readback
        write_word(32'h4, 32'h1234_5678);
        write_word(32'h8, 32'hCAFE_F00D);
        read_check("rb_0x4", 32'h4, 32'h1234_5678);
        read_check("rb_0x8", 32'h8, 32'hCAFE_F00D);
        read_check("rb_0xc", 32'hC, 32'h0);

        // Combinational read, one-edge write latency, no forwarding
        bus.address      = 32'h20;
        bus.write_data   = 32'hA5A5_A5A5;
        bus.write_enable = 1'b1;
        #1;
        check("same_addr_before_edge", 32'h0);
        tick();
        bus.write_enable = 1'b0;
        check("same_addr_after_edge", 32'hA5A5_A5A5);

        // Low address bits ignored, aliasing modulo 4 KiB
        write_word(32'h40, 32'h1111_1111);
        read_check("misaligned_0x41", 32'h41, 32'h1111_1111);
        read_check("misaligned_0x43", 32'h43, 32'h1111_1111);
        write_word(32'h1000, 32'h2222_2222);
        read_check("alias_0x0", 32'h0, 32'h2222_2222);
        read_check("alias_high_0xfffff004", 32'hFFFF_F004, 32'h1234_5678);

        // Back-to-back writes to the same word: last wins
        write_word(32'h50, 32'h0000_0001);
        write_word(32'h50, 32'h0000_0002);
        read_check("last_write_wins", 32'h50, 32'h0000_0002);

        // Reset beats a same-cycle write
        bus.address      = 32'h30;
        bus.write_data   = 32'hFFFF_FFFF;
        bus.write_enable = 1'b1;
        rst              = 1'b1;
        tick();
        rst              = 1'b0;
        bus.write_enable = 1'b0;
        read_check("rst_priority_0x30", 32'h30, 32'h0);
        read_check("rst_cleared_0x4", 32'h4, 32'h0);
        read_check("rst_cleared_0x50", 32'h50, 32'h0);

        // Writes resume on the first edge after reset
        write_word(32'h4, 32'h1234_5678);
        read_check("write_after_rst", 32'h4, 32'h1234_5678);

        // Write-disable hold while write_data toggles
        bus.address = 32'h4;
        for (int i = 0; i < 10; i++) begin
            bus.write_data = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            tick();
        end
        check("we_low_hold", 32'h1234_5678);
        read_check("we_low_neighbour", 32'h8, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
